// File: rtl/dmem_bus_bridge.sv
// Bridges the core's 64-bit data bus onto a 32-bit req/ack memory bus,
// issuing up to two word beats per access and stalling the core meanwhile.
module dmem_bus_bridge #(
    parameter int unsigned MEM_AW  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iReadEnable,
    input  logic              iWriteEnable,
    input  logic [63:0]       iAddress,
    input  logic [63:0]       iWriteData,
    input  logic [7:0]        iByteEnable,
    output logic [63:0]       oReadData,
    output logic              oStall,
    output logic              oError,
    output logic              oMemReq,
    output logic              oMemWe,
    output logic [MEM_AW-1:0] oMemAddr,
    output logic [31:0]       oMemWData,
    output logic [3:0]        oMemBE,
    input  logic              iMemAck,
    input  logic [31:0]       iMemRData
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic              hi_need_q, hi_need_d;
    logic [31:0]       hi_wdata_q, hi_wdata_d;
    logic [3:0]        hi_be_q, hi_be_d;
    logic [31:0]       lo_rdata_q, lo_rdata_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              mwe_q, mwe_d;
    logic [MEM_AW-1:0] maddr_q, maddr_d;
    logic [31:0]       mwdata_q, mwdata_d;
    logic [3:0]        mbe_q, mbe_d;
    logic [63:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              beat_ack;
    logic              beat_timeout;
    logic [MEM_AW-1:0] lo_base;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^iAddress;
    assign lo_base      = {iAddress[MEM_AW-1:3], 3'b000};
    assign beat_ack     = req_q & iMemAck;
    assign beat_timeout = req_q & ~iMemAck & (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        hi_need_d  = hi_need_q;
        hi_wdata_d = hi_wdata_q;
        hi_be_d    = hi_be_q;
        lo_rdata_d = lo_rdata_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        mwe_d      = mwe_q;
        maddr_d    = maddr_q;
        mwdata_d   = mwdata_q;
        mbe_d      = mbe_q;
        rdata_d    = rdata_q;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (iReadEnable | iWriteEnable) begin
                    we_d       = iWriteEnable;
                    hi_need_d  = |iByteEnable[7:4];
                    hi_wdata_d = iWriteData[63:32];
                    hi_be_d    = iByteEnable[7:4];
                    lo_rdata_d = '0;
                    cnt_d      = '0;
                    if (iReadEnable & iWriteEnable) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else if (|iByteEnable[3:0]) begin
                        state_d  = S_LO;
                        req_d    = 1'b1;
                        mwe_d    = iWriteEnable;
                        maddr_d  = lo_base;
                        mwdata_d = iWriteData[31:0];
                        mbe_d    = iByteEnable[3:0];
                    end else if (|iByteEnable[7:4]) begin
                        state_d  = S_HI;
                        req_d    = 1'b1;
                        mwe_d    = iWriteEnable;
                        maddr_d  = lo_base + MEM_AW'(4);
                        mwdata_d = iWriteData[63:32];
                        mbe_d    = iByteEnable[7:4];
                    end else begin
                        state_d = S_DONE;
                        if (iReadEnable) rdata_d = '0;
                    end
                end
            end
            S_LO: begin
                if (beat_ack) begin
                    lo_rdata_d = iMemRData;
                    cnt_d      = '0;
                    // Back-to-back high beat keeps req asserted across the edge.
                    if (hi_need_q) begin
                        state_d  = S_HI;
                        maddr_d  = maddr_q + MEM_AW'(4);
                        mwdata_d = hi_wdata_q;
                        mbe_d    = hi_be_q;
                    end else begin
                        state_d = S_DONE;
                        req_d   = 1'b0;
                        if (!we_q) rdata_d = {32'h0, iMemRData};
                    end
                end else if (beat_timeout) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HI: begin
                if (beat_ack) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    if (!we_q) rdata_d = {iMemRData, lo_rdata_q};
                end else if (beat_timeout) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            hi_need_q  <= 1'b0;
            hi_wdata_q <= '0;
            hi_be_q    <= '0;
            lo_rdata_q <= '0;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            mwe_q      <= 1'b0;
            maddr_q    <= '0;
            mwdata_q   <= '0;
            mbe_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            hi_need_q  <= hi_need_d;
            hi_wdata_q <= hi_wdata_d;
            hi_be_q    <= hi_be_d;
            lo_rdata_q <= lo_rdata_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            mwe_q      <= mwe_d;
            maddr_q    <= maddr_d;
            mwdata_q   <= mwdata_d;
            mbe_q      <= mbe_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign oStall    = (iReadEnable | iWriteEnable) & (state_q != S_DONE);
    assign oReadData = rdata_q;
    assign oError    = err_q;
    assign oMemReq   = req_q;
    assign oMemWe    = mwe_q;
    assign oMemAddr  = maddr_q;
    assign oMemWData = mwdata_q;
    assign oMemBE    = mbe_q;

endmodule
